// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared types and constants for the configuration chain loader
package cfg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } cfg_state_t;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   localparam int DEF_CHAIN_LEN = 256;
   localparam int DEF_WORD_W    = 32;

endpackage

// File: rtl/cfg_crc16.sv
// rtl/cfg_crc16.sv - bit-serial CRC-16-CCITT, one data bit per enabled clock
module cfg_crc16
   import cfg_pkg::*;
(
   input  logic        clk,
   input  logic        nrst,
   input  logic        clr,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);

   logic [15:0] crc_q, crc_d;
   logic        fb;

   always_comb begin
      crc_d = crc_q;
      fb    = crc_q[15] ^ din;
      if (clr) begin
         crc_d = CRC_INIT;
      end else if (en) begin
         crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         crc_q <= CRC_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/cfg_chain_loader.sv
// rtl/cfg_chain_loader.sv - serialises config words MSB-first onto the fabric chain; CRC check under CFG_LOADER_CRC_EN
module cfg_chain_loader
   import cfg_pkg::*;
#(
   parameter int CHAIN_LEN = DEF_CHAIN_LEN,
   parameter int WORD_W    = DEF_WORD_W
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] word_in,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              cfg_en,
   output logic              cfg_data
);

   localparam int BC_W     = $clog2(CHAIN_LEN + 1);
   localparam int WC_W     = $clog2(WORD_W + 1);
   localparam int LAST_R   = CHAIN_LEN % WORD_W;
   localparam int LAST_N   = (LAST_R == 0) ? WORD_W : LAST_R;
   localparam int LAST_SHL = WORD_W - LAST_N;

   localparam logic [BC_W-1:0] CHAIN_END = BC_W'(CHAIN_LEN);
   localparam logic [BC_W-1:0] LAST_BASE = BC_W'(CHAIN_LEN - LAST_N);
   localparam logic [WC_W-1:0] FULL_N    = WC_W'(WORD_W);
   localparam logic [WC_W-1:0] PART_N    = WC_W'(LAST_N);

   cfg_state_t        state_q, state_d;
   logic [WORD_W-1:0] sh_q, sh_d;
   logic [WC_W-1:0]   wbits_q, wbits_d;
   logic [BC_W-1:0]   loaded_q, loaded_d;
   logic [BC_W-1:0]   shifted_q, shifted_d;
   logic              cfg_en_q, cfg_en_d;
   logic              cfg_data_q, cfg_data_d;

   logic              hs, last_word, last_bit;
   logic [WORD_W-1:0] aligned;
   logic [WC_W-1:0]   word_n;

`ifdef CFG_LOADER_CRC_EN
   logic              error_q, error_d;
   logic              crc_clr;
   logic [15:0]       crc;

   cfg_crc16 u_crc (
      .clk  (clk),
      .nrst (nrst),
      .clr  (crc_clr),
      .en   (cfg_en_q),
      .din  (cfg_data_q),
      .crc  (crc)
   );
`endif

   // wbits_q counts the current word's bits still to finish, including the one on cfg_data
   always_comb begin
      word_ready = (state_q == ST_LOAD) && (loaded_q < CHAIN_END) && (wbits_q <= WC_W'(1));
`ifdef CFG_LOADER_CRC_EN
      word_ready = word_ready || (state_q == ST_CHECK);
`endif
   end

   assign hs        = word_valid && word_ready;
   assign last_word = (loaded_q == LAST_BASE);
   assign last_bit  = cfg_en_q && (shifted_q == CHAIN_END - BC_W'(1));
   assign aligned   = last_word ? (word_in << LAST_SHL) : word_in;
   assign word_n    = last_word ? PART_N : FULL_N;

   always_comb begin
      state_d    = state_q;
      sh_d       = sh_q;
      wbits_d    = wbits_q;
      loaded_d   = loaded_q;
      shifted_d  = shifted_q;
      cfg_en_d   = 1'b0;
      cfg_data_d = cfg_data_q;
`ifdef CFG_LOADER_CRC_EN
      error_d    = error_q;
      crc_clr    = 1'b0;
`endif
      if (cfg_en_q) begin
         if (shifted_q != CHAIN_END) shifted_d = shifted_q + BC_W'(1);
         if (wbits_q != '0)          wbits_d   = wbits_q - WC_W'(1);
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_LOAD;
               sh_d      = '0;
               wbits_d   = '0;
               loaded_d  = '0;
               shifted_d = '0;
`ifdef CFG_LOADER_CRC_EN
               error_d   = 1'b0;
               crc_clr   = 1'b1;
`endif
            end
         end
         ST_LOAD: begin
            if (hs) begin
               cfg_en_d   = 1'b1;
               cfg_data_d = aligned[WORD_W-1];
               sh_d       = aligned << 1;
               wbits_d    = word_n;
               loaded_d   = loaded_q + BC_W'(word_n);
            end else if (wbits_q > WC_W'(1)) begin
               cfg_en_d   = 1'b1;
               cfg_data_d = sh_q[WORD_W-1];
               sh_d       = sh_q << 1;
            end
            if (last_bit) begin
`ifdef CFG_LOADER_CRC_EN
               state_d = ST_CHECK;
`else
               state_d = ST_DONE;
`endif
            end
         end
`ifdef CFG_LOADER_CRC_EN
         ST_CHECK: begin
            if (hs) begin
               state_d = ST_DONE;
               error_d = (word_in[15:0] != crc);
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      // abort wins over start and any handshake; the chain keeps its partial content
      if (abort) begin
         state_d    = ST_IDLE;
         sh_d       = '0;
         wbits_d    = '0;
         loaded_d   = '0;
         shifted_d  = '0;
         cfg_en_d   = 1'b0;
         cfg_data_d = 1'b0;
`ifdef CFG_LOADER_CRC_EN
         error_d    = 1'b0;
         crc_clr    = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= ST_IDLE;
         sh_q       <= '0;
         wbits_q    <= '0;
         loaded_q   <= '0;
         shifted_q  <= '0;
         cfg_en_q   <= 1'b0;
         cfg_data_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sh_q       <= sh_d;
         wbits_q    <= wbits_d;
         loaded_q   <= loaded_d;
         shifted_q  <= shifted_d;
         cfg_en_q   <= cfg_en_d;
         cfg_data_q <= cfg_data_d;
      end
   end

`ifdef CFG_LOADER_CRC_EN
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         error_q <= 1'b0;
      end else begin
         error_q <= error_d;
      end
   end
   assign error = error_q;
`else
   assign error = 1'b0;
`endif

   assign busy     = (state_q == ST_LOAD) || (state_q == ST_CHECK);
   assign done     = (state_q == ST_DONE);
   assign cfg_en   = cfg_en_q;
   assign cfg_data = cfg_data_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb/tb_cfg_chain_loader.sv - directed bench for cfg_chain_loader (256-bit and 40-bit chains); CRC cases under CFG_LOADER_CRC_EN
module tb_cfg_chain_loader;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   logic        a_start, a_abort, a_valid, a_ready, a_busy, a_done, a_error, a_en, a_data;
   logic [31:0] a_word;
   logic        b_start, b_abort, b_valid, b_ready, b_busy, b_done, b_error, b_en, b_data;
   logic [31:0] b_word;

   cfg_chain_loader #(.CHAIN_LEN(256), .WORD_W(32)) u_dut_a (
      .clk(clk), .nrst(nrst), .start(a_start), .abort(a_abort),
      .word_in(a_word), .word_valid(a_valid), .word_ready(a_ready),
      .busy(a_busy), .done(a_done), .error(a_error),
      .cfg_en(a_en), .cfg_data(a_data)
   );

   cfg_chain_loader #(.CHAIN_LEN(40), .WORD_W(32)) u_dut_b (
      .clk(clk), .nrst(nrst), .start(b_start), .abort(b_abort),
      .word_in(b_word), .word_valid(b_valid), .word_ready(b_ready),
      .busy(b_busy), .done(b_done), .error(b_error),
      .cfg_en(b_en), .cfg_data(b_data)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit a_bitq[$];
   int a_cycq[$];
   bit b_bitq[$];
   int b_cycq[$];

   always @(negedge clk) begin
      if (a_en) begin
         a_bitq.push_back(a_data);
         a_cycq.push_back(cyc);
      end
      if (b_en) begin
         b_bitq.push_back(b_data);
         b_cycq.push_back(cyc);
      end
   end

   int vectors = 0;
   int miscompares = 0;
   bit expq[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic exp_add(input logic [31:0] w, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) expq.push_back(w[i]);
   endtask

   function automatic logic [15:0] crc_exp();
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      foreach (expq[i]) begin
         fb = c[15] ^ expq[i];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

   task automatic start_load(input bit on_b);
      if (on_b) b_start = 1'b1; else a_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      a_start = 1'b0;
   endtask

   task automatic push(input bit on_b, input logic [31:0] w);
      int n;
      n = 0;
      if (on_b) begin b_word = w; b_valid = 1'b1; end
      else      begin a_word = w; a_valid = 1'b1; end
      do begin
         @(negedge clk);
         n++;
      end while (!(on_b ? b_ready : a_ready) && n < 1000);
      if (n >= 1000) check("push timeout", 0, 1);
      @(posedge clk); #1;
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   task automatic wait_ready_a();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!a_ready && n < 1000);
      if (n >= 1000) check("ready timeout", 0, 1);
   endtask

   task automatic wait_done(input bit on_b, input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(on_b ? b_done : a_done) && n < 3000);
      check({tag, " done"}, on_b ? b_done : a_done, 1);
`ifndef CFG_LOADER_CRC_EN
      check({tag, " done latency"}, cyc - (on_b ? b_cycq[b_cycq.size()-1] : a_cycq[a_cycq.size()-1]), 1);
`endif
   endtask

   task automatic wait_bits_a(input int base, input int nbits);
      int n;
      n = 0;
      while (a_bitq.size() - base < nbits && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 2000) check("bit wait timeout", 0, 1);
   endtask

   task automatic verify(input bit on_b, input string tag, input int base, input int span);
      int n, errs, first, last;
      n = (on_b ? b_bitq.size() : a_bitq.size()) - base;
      check({tag, " bit count"}, n, expq.size());
      errs = 0;
      for (int i = 0; i < n && i < expq.size(); i++)
         if ((on_b ? b_bitq[base+i] : a_bitq[base+i]) != expq[i]) errs++;
      check({tag, " bit errors"}, errs, 0);
      first = 0;
      last  = -1;
      if (n > 0) begin
         first = on_b ? b_cycq[base] : a_cycq[base];
         last  = on_b ? b_cycq[base+n-1] : a_cycq[base+n-1];
      end
      check({tag, " en span"}, last - first + 1, span);
   endtask

   task automatic a_stream(input string tag, input logic [31:0] w, input bit gaps, input bit flip);
      int base;
      base = a_bitq.size();
      expq.delete();
      for (int i = 0; i < 8; i++) exp_add(w, 32);
      start_load(1'b0);
      check({tag, " busy"}, a_busy, 1);
      for (int i = 0; i < 8; i++) begin
         push(1'b0, w);
         if (gaps && i < 7) begin
            wait_ready_a();
            repeat (3) @(posedge clk);
            #1;
         end
      end
`ifdef CFG_LOADER_CRC_EN
      push(1'b0, {16'h0000, crc_exp() ^ {15'h0000, flip}});
`endif
      wait_done(1'b0, tag);
      check({tag, " error"}, a_error, {31'h0, flip});
      check({tag, " ready in DONE"}, a_ready, 0);
      verify(1'b0, tag, base, gaps ? 256 + 21 : 256);
   endtask

   initial begin
      int base;
      logic [7:0] tail;
      a_start = 0; a_abort = 0; a_valid = 0; a_word = '0;
      b_start = 0; b_abort = 0; b_valid = 0; b_word = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset word_ready", a_ready, 0);
      check("reset busy", a_busy, 0);
      check("reset done", a_done, 0);
      check("reset error", a_error, 0);
      check("reset cfg_en", a_en, 0);
      check("reset cfg_data", a_data, 0);
      @(posedge clk); #1;
      nrst = 1'b1;

      a_stream("stream", 32'hFFFF_0000, 1'b0, 1'b0);

      // 40-bit chain: one full word then the low 8 bits of a second
      base = b_bitq.size();
      expq.delete();
      exp_add(32'hA5A5_A5A5, 32);
      exp_add(32'h0000_00C3, 8);
      start_load(1'b1);
      push(1'b1, 32'hA5A5_A5A5);
      push(1'b1, 32'hFFFF_FFC3);
`ifdef CFG_LOADER_CRC_EN
      push(1'b1, {16'h0000, crc_exp()});
`endif
      wait_done(1'b1, "partial");
      check("partial error", b_error, 0);
      verify(1'b1, "partial", base, 40);
      tail = '0;
      for (int i = 0; i < 8; i++) tail = {tail[6:0], b_bitq[b_bitq.size()-8+i]};
      check("partial tail", tail, 8'hC3);

      a_stream("stall", 32'hFFFF_0000, 1'b1, 1'b0);

      // abort during the 100th shift cycle
      base = a_bitq.size();
      start_load(1'b0);
      a_word = 32'hFFFF_0000;
      a_valid = 1'b1;
      wait_bits_a(base, 99);
      a_abort = 1'b1;
      a_start = 1'b1;
      @(posedge clk); #1;
      a_abort = 1'b0;
      a_start = 1'b0;
      a_valid = 1'b0;
      @(negedge clk);
      check("abort cfg_en", a_en, 0);
      check("abort busy", a_busy, 0);
      check("abort done", a_done, 0);
      check("abort ready", a_ready, 0);
      check("abort bits shifted", a_bitq.size() - base, 100);
      @(posedge clk); #1;
      a_stream("reload", 32'hFFFF_0000, 1'b0, 1'b0);

      // reset during the 50th shift cycle
      base = a_bitq.size();
      start_load(1'b0);
      a_word = 32'hFFFF_FFFF;
      a_valid = 1'b1;
      wait_bits_a(base, 49);
      check("pre-reset cfg_data", a_data, 1);
      nrst = 1'b0;
      #1;
      check("mid reset cfg_en", a_en, 0);
      check("mid reset cfg_data", a_data, 0);
      check("mid reset busy", a_busy, 0);
      check("mid reset ready", a_ready, 0);
      a_valid = 1'b0;
      @(posedge clk); #1;
      nrst = 1'b1;
      @(negedge clk);
      check("post reset busy", a_busy, 0);
      check("post reset done", a_done, 0);
      @(posedge clk); #1;
      a_stream("after reset", 32'h1234_5678, 1'b0, 1'b0);

`ifdef CFG_LOADER_CRC_EN
      a_stream("crc flipped", 32'hFFFF_0000, 1'b0, 1'b1);
      start_load(1'b0);
      @(negedge clk);
      check("restart clears error", a_error, 0);
      check("restart clears done", a_done, 0);
      a_abort = 1'b1;
      @(posedge clk); #1;
      a_abort = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cfg_chain_loader.md
# cfg_chain_loader

Bitstream loader sitting directly upstream of the fabric's serial configuration chain of switch boxes and other tiles. It accepts parallel configuration words over a valid/ready handshake and serialises them MSB-first onto the chain's `config_data_in`/`config_en` pair at one bit per clock. It tracks the exact chain length and reports completion. An optional CRC check rejects corrupted bitstreams. While it shifts, downstream tiles see `config_en` high and hold their routed outputs at 0.

## Interface
- `CHAIN_LEN`, default 256: total configuration bits in the chain (one 32-wire switch box = 256). Must be ≥ 1.
- `WORD_W`, default 32: input word width. Must be ≥ 16.
- `clk` input 1: clock.
- `nrst` input 1: reset, asynchronous, active-low.
- `start` input 1: begin a load. Sampled only in IDLE or DONE.
- `abort` input 1: cancel the load; return to IDLE.
- `word_in` input WORD_W: configuration word.
- `word_valid` input 1: `word_in` is valid.
- `word_ready` output 1: loader accepts a word this cycle.
- `busy` output 1: high in LOAD or CHECK.
- `done` output 1: load complete. Level signal, held until the next `start` or `abort`.
- `error` output 1: CRC mismatch. Level signal, held like `done`. Tied 0 without the macro.
- `cfg_en` output 1: drives the chain's `config_en`.
- `cfg_data` output 1: drives the chain's `config_data_in`.

## Operation
- States: IDLE, LOAD, CHECK (macro only), DONE.
- IDLE/DONE + `start` → LOAD. Entering LOAD clears the bit counter, `done`, `error` and the CRC (CRC init 16'hFFFF).
- `start` in LOAD or CHECK is ignored.
- LOAD:
  - Word framing: `ceil(CHAIN_LEN/WORD_W)` words are accepted.
  - Full words are shifted from bit WORD_W-1 down to bit 0.
  - If R = CHAIN_LEN mod WORD_W is nonzero, the final word shifts only its bits R-1 down to 0; its upper bits are ignored.
  - Holding: one shift register plus a per-word bit counter. `word_ready` is high in LOAD when the shift register is empty, or when it holds exactly one bit left to shift and more words remain. This allows gapless streaming.
  - A handshake occurs on `word_valid && word_ready`.
  - When no bit is available, `cfg_en` is low and the chain holds its state (stall).
  - After the last of CHAIN_LEN bits is shifted: without the macro → DONE; with the macro → CHECK.
- CHECK: `word_ready` high; accepts one word. Its bits [15:0] are compared with the CRC. Match → DONE, `error`=0. Mismatch → DONE, `error`=1.
- `abort` in any state → IDLE next cycle; `cfg_en` low from that edge. `done`/`error` are cleared, the counter is cleared, and any buffered word is discarded. The chain keeps whatever partial content it has.
- `abort` takes priority over a simultaneous `start` or handshake.
- `word_valid` in IDLE/DONE is not accepted (`word_ready`=0).
- CRC: CRC-16-CCITT, polynomial 16'h1021, updated once per shifted bit with the bit value of `cfg_data`. It covers exactly CHAIN_LEN bits.
- Counters: the total bit counter is `$clog2(CHAIN_LEN+1)` bits wide; the per-word counter is `$clog2(WORD_W+1)` bits wide. Neither wraps; both saturate at the terminal count.

## Timing
- Reset values: `word_ready`=0, `busy`=0, `done`=0, `error`=0, `cfg_en`=0, `cfg_data`=0. The state register resets to IDLE.
- `cfg_en` and `cfg_data` are registered outputs.
- Latency: a word accepted at edge k has its first bit on `cfg_data` with `cfg_en`=1 during cycle k+1.
- Back-to-back valid words give `cfg_en` high for exactly CHAIN_LEN consecutive cycles.
- `busy` rises the cycle after `start` is sampled.
- Without the macro, `done` rises on the edge after the last shift cycle.
- With the macro, `done` rises on the edge after the CRC-word handshake.
- A `nrst` assertion mid-load forces all outputs to their reset values immediately. The chain shares `nrst` and resets to all-ones (all routes disabled).

## Configuration
- Macro: `CFG_LOADER_CRC_EN`.
- Defined: CHECK state, the CRC register and the trailing CRC word are compiled in; `error` is functional.
- Undefined: no CRC logic, no trailing word; LOAD → DONE directly; `error` is tied 0.

## Structure
- Shared package `cfg_pkg`: the state enum typedef `cfg_state_t`, the `CRC_POLY`=16'h1021 and `CRC_INIT`=16'hFFFF constants, and the default `CHAIN_LEN`/`WORD_W` localparams.
- One sub-module: `cfg_crc16`, a bit-serial CRC with clear, enable, data-bit and 16-bit state output. It is instantiated only under the macro.

## Test plan
- Streaming, CHAIN_LEN=256, WORD_W=32: `start` then 8 back-to-back words 32'hFFFF_0000 → `cfg_en` high 256 consecutive cycles; the cfg_data pattern is 16 ones then 16 zeros, repeated; `done`=1 on the following edge.
- Partial word, CHAIN_LEN=40: words 32'hA5A5_A5A5 then 32'h0000_00C3 → 40 bits shifted; the last 8 bits are 1100_0011; `cfg_en` then drops; `done`=1.
- Stall, CHAIN_LEN=256: `word_valid` deasserted 3 cycles between each word → `cfg_en` low exactly during the gaps; total high cycles = 256; the bit sequence is identical to the streaming case.
- Abort: assert `abort` after 100 shift cycles → IDLE next cycle; `cfg_en`=0, `busy`=0, `done`=0. A later `start` reloads the full 256 bits.
- CRC (macro on), CHAIN_LEN=256: correct CRC word → `done`=1, `error`=0. Same stream with bit [0] of the CRC word flipped → `done`=1, `error`=1.
- Reset mid-load: `nrst` low at cycle 50 of the shift → all outputs 0 immediately; IDLE after release; a `start` with the new stream completes normally.
